// File: rtl/key_pulse_gen_pkg.sv
// Shared definitions for the key pulse front-end: FSM state encoding and
// default timing for the 12 MHz board clock.
package key_pulse_gen_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_HOLD   = 2'd1,
        ST_REPEAT = 2'd2
    } key_state_t;

    localparam int DEF_DEBOUNCE_CYCLES = 240000;   // 20 ms
    localparam int DEF_HOLD_CYCLES     = 6000000;  // 500 ms
    localparam int DEF_REPEAT_CYCLES   = 1200000;  // 100 ms
    localparam int DEF_CNT_W           = 23;

endpackage

// File: rtl/key_pulse_gen_if.sv
// Button-side bundle: raw active-low keys in, debounced levels and strobes out.
interface key_pulse_gen_if;
    logic key_up_n;
    logic key_down_n;
    logic up_pulse;
    logic down_pulse;
    logic up_level;
    logic down_level;

    modport master (
        output key_up_n, key_down_n,
        input  up_pulse, down_pulse, up_level, down_level
    );

    modport slave (
        input  key_up_n, key_down_n,
        output up_pulse, down_pulse, up_level, down_level
    );
endinterface

// File: rtl/key_pulse_gen_debounce_ch.sv
// One key channel: 2-flop synchronizer, counter debounce, press pulse and
// auto-repeat FSM.
//
//   state     | meaning
//   ST_IDLE   | key released, waiting for debounced press
//   ST_HOLD   | pressed, counting to first auto-repeat (or inhibited)
//   ST_REPEAT | pressed, emitting a pulse every REPEAT_CYCLES
module key_debounce_ch
    import key_pulse_gen_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int HOLD_CYCLES     = DEF_HOLD_CYCLES,
    parameter int REPEAT_CYCLES   = DEF_REPEAT_CYCLES,
    parameter int CNT_W           = DEF_CNT_W
) (
    input  logic clk_in,
    input  logic rst_n_in,
    input  logic key_n,
    input  logic inhibit_repeat,
    output logic pulse,
    output logic level
);

    localparam longint CNT_MAX = (longint'(1) << CNT_W) - 1;

    if (DEBOUNCE_CYCLES < 2 || HOLD_CYCLES < 2 || REPEAT_CYCLES < 2) begin : g_bad_cycles
        $error("key_debounce_ch: every *_CYCLES parameter must be >= 2");
    end
    if (longint'(DEBOUNCE_CYCLES) - 1 > CNT_MAX || longint'(HOLD_CYCLES) - 1 > CNT_MAX ||
        longint'(REPEAT_CYCLES) - 1 > CNT_MAX) begin : g_bad_width
        $error("key_debounce_ch: CNT_W too narrow for the timing parameters");
    end

    localparam logic [CNT_W-1:0] DEB_TC = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] HLD_TC = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] REP_TC = CNT_W'(REPEAT_CYCLES - 1);

    logic             sync1, sync2, s;
    logic [CNT_W-1:0] dcnt, dcnt_nxt;
    logic [CNT_W-1:0] rcnt, rcnt_nxt;
    logic             level_nxt, pulse_nxt;
    key_state_t       state, state_nxt;

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            sync1 <= 1'b1;
            sync2 <= 1'b1;
            dcnt  <= '0;
            rcnt  <= '0;
            level <= 1'b0;
            pulse <= 1'b0;
            state <= ST_IDLE;
        end else begin
            sync1 <= key_n;
            sync2 <= sync1;
            dcnt  <= dcnt_nxt;
            rcnt  <= rcnt_nxt;
            level <= level_nxt;
            pulse <= pulse_nxt;
            state <= state_nxt;
        end
    end

    assign s = ~sync2;

    // The counter only ever reaches DEB_TC, where it clears, so it cannot wrap.
    always_comb begin
        level_nxt = level;
        dcnt_nxt  = '0;
        if (s != level) begin
            if (dcnt == DEB_TC) begin
                level_nxt = s;
            end else begin
                dcnt_nxt = dcnt + 1'b1;
            end
        end
    end

    // Decisions use the level being registered this edge, so the press pulse
    // lines up with the level rise and a falling level never pulses.
    always_comb begin
        state_nxt = state;
        rcnt_nxt  = rcnt;
        pulse_nxt = 1'b0;
        if (!level_nxt) begin
            state_nxt = ST_IDLE;
            rcnt_nxt  = '0;
        end else if (!level) begin
            pulse_nxt = 1'b1;
            state_nxt = ST_HOLD;
            rcnt_nxt  = '0;
        end else if (inhibit_repeat) begin
            state_nxt = ST_HOLD;
            rcnt_nxt  = '0;
        end else begin
            case (state)
                ST_HOLD: begin
                    if (rcnt == HLD_TC) begin
                        pulse_nxt = 1'b1;
                        state_nxt = ST_REPEAT;
                        rcnt_nxt  = '0;
                    end else begin
                        rcnt_nxt = rcnt + 1'b1;
                    end
                end
                ST_REPEAT: begin
                    if (rcnt == REP_TC) begin
                        pulse_nxt = 1'b1;
                        rcnt_nxt  = '0;
                    end else begin
                        rcnt_nxt = rcnt + 1'b1;
                    end
                end
                ST_IDLE: begin
                    state_nxt = ST_HOLD;
                    rcnt_nxt  = '0;
                end
                default: begin
                    state_nxt = ST_IDLE;
                    rcnt_nxt  = '0;
                end
            endcase
        end
    end

endmodule

// File: rtl/key_pulse_gen.sv
// Two-key front end: debounced UP/DOWN levels and press/auto-repeat strobes.
// Auto-repeat is suppressed on both keys while both are held.
module key_pulse_gen
    import key_pulse_gen_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int HOLD_CYCLES     = DEF_HOLD_CYCLES,
    parameter int REPEAT_CYCLES   = DEF_REPEAT_CYCLES,
    parameter int CNT_W           = DEF_CNT_W
) (
    input  logic          clk_in,
    input  logic          rst_n_in,
    key_pulse_gen_if.slave kp
);

    logic up_lvl, down_lvl, up_pls, down_pls;
    logic inhibit_repeat;

    assign inhibit_repeat = up_lvl & down_lvl;

    key_debounce_ch #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .HOLD_CYCLES     (HOLD_CYCLES),
        .REPEAT_CYCLES   (REPEAT_CYCLES),
        .CNT_W           (CNT_W)
    ) u_up (
        .clk_in         (clk_in),
        .rst_n_in       (rst_n_in),
        .key_n          (kp.key_up_n),
        .inhibit_repeat (inhibit_repeat),
        .pulse          (up_pls),
        .level          (up_lvl)
    );

    key_debounce_ch #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .HOLD_CYCLES     (HOLD_CYCLES),
        .REPEAT_CYCLES   (REPEAT_CYCLES),
        .CNT_W           (CNT_W)
    ) u_down (
        .clk_in         (clk_in),
        .rst_n_in       (rst_n_in),
        .key_n          (kp.key_down_n),
        .inhibit_repeat (inhibit_repeat),
        .pulse          (down_pls),
        .level          (down_lvl)
    );

    assign kp.up_pulse   = up_pls;
    assign kp.down_pulse = down_pls;
    assign kp.up_level   = up_lvl;
    assign kp.down_level = down_lvl;

endmodule

// File: tb/tb_key_pulse_gen.sv
// Self-checking bench for key_pulse_gen: directed scenarios with literal pulse
// schedules plus random key activity compared every cycle to a timing model.
module tb_key_pulse_gen;

    localparam int DEB = 4;
    localparam int HLD = 10;
    localparam int REP = 3;

    logic clk_in = 1'b0;
    logic rst_n_in;
    int   checks = 0;
    int   failures = 0;

    key_pulse_gen_if kp_if ();

    key_pulse_gen #(
        .DEBOUNCE_CYCLES (DEB),
        .HOLD_CYCLES     (HLD),
        .REPEAT_CYCLES   (REP),
        .CNT_W           (8)
    ) dut (
        .clk_in   (clk_in),
        .rst_n_in (rst_n_in),
        .kp       (kp_if)
    );

    always #5 clk_in = ~clk_in;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s at %0t: actual=%0d required=%0d", name, $time, act, exp);
        end
    endtask

    function automatic string q2s(input int q[$]);
        string r = "{";
        foreach (q[i]) r = {r, $sformatf("%0d ", q[i])};
        return {r, "}"};
    endfunction

    task automatic chk_list(input string name, input int act[$], input int exp[$]);
        bit ok = (act.size() == exp.size());
        if (ok) foreach (exp[i]) if (act[i] != exp[i]) ok = 0;
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL %s: actual=%s required=%s", name, q2s(act), q2s(exp));
        end
    endtask

    // Behavioural model: a level flips once the synchronized key has disagreed
    // with it for DEB consecutive cycles; pulses follow from the time held
    // since the press (or since the last cycle both keys were held).
    bit m_ff1[2], m_ff2[2], m_lvl[2], m_pls[2];
    int m_run[2], m_age[2];

    initial forever begin
        @(posedge clk_in or negedge rst_n_in);
        if (!rst_n_in) begin
            for (int k = 0; k < 2; k++) begin
                m_ff1[k] = 1; m_ff2[k] = 1; m_lvl[k] = 0; m_pls[k] = 0;
                m_run[k] = 0; m_age[k] = 0;
            end
        end else begin
            bit inh;
            bit keys[2];
            inh = m_lvl[0] & m_lvl[1];
            keys[0] = kp_if.key_up_n;
            keys[1] = kp_if.key_down_n;
            for (int k = 0; k < 2; k++) begin
                bit s, nl;
                s  = ~m_ff2[k];
                nl = m_lvl[k];
                if (s != m_lvl[k]) begin
                    m_run[k]++;
                    if (m_run[k] == DEB) begin
                        nl = s;
                        m_run[k] = 0;
                    end
                end else begin
                    m_run[k] = 0;
                end
                if (!nl) begin
                    m_pls[k] = 0;
                end else if (!m_lvl[k]) begin
                    m_pls[k] = 1;
                    m_age[k] = 0;
                end else if (inh) begin
                    m_pls[k] = 0;
                    m_age[k] = 0;
                end else begin
                    m_age[k]++;
                    m_pls[k] = (m_age[k] == HLD) ||
                               (m_age[k] > HLD && ((m_age[k] - HLD) % REP) == 0);
                end
                m_ff2[k] = m_ff1[k];
                m_ff1[k] = keys[k];
                m_lvl[k] = nl;
            end
        end
    end

    bit done = 0;
    initial forever begin
        @(negedge clk_in);
        if (done) break;
        if (rst_n_in) begin
            chk("cmp_up_pulse",   int'(kp_if.up_pulse),   int'(m_pls[0]));
            chk("cmp_up_level",   int'(kp_if.up_level),   int'(m_lvl[0]));
            chk("cmp_down_pulse", int'(kp_if.down_pulse), int'(m_pls[1]));
            chk("cmp_down_level", int'(kp_if.down_level), int'(m_lvl[1]));
        end
    end

    // Per-scenario recording, cycle numbers relative to the scenario start.
    int rel;
    int up_q[$], down_q[$];
    int up_rise, up_fall, down_rise, down_fall;
    int none[$];

    task automatic clear_rec();
        rel = 0;
        up_q.delete();
        down_q.delete();
        up_rise = -1; up_fall = -1; down_rise = -1; down_fall = -1;
    endtask

    task automatic step(input bit up_n, input bit down_n);
        kp_if.key_up_n   = up_n;
        kp_if.key_down_n = down_n;
        @(posedge clk_in);
        #1;
        rel++;
        if (kp_if.up_pulse)   up_q.push_back(rel);
        if (kp_if.down_pulse) down_q.push_back(rel);
        if (kp_if.up_level && up_rise < 0) up_rise = rel;
        if (!kp_if.up_level && up_rise >= 0 && up_fall < 0) up_fall = rel;
        if (kp_if.down_level && down_rise < 0) down_rise = rel;
        if (!kp_if.down_level && down_rise >= 0 && down_fall < 0) down_fall = rel;
    endtask

    initial begin
        kp_if.key_up_n   = 1'b1;
        kp_if.key_down_n = 1'b1;
        rst_n_in = 1'b0;
        clear_rec();
        repeat (3) @(posedge clk_in);
        #1;
        chk("reset_up_pulse",   int'(kp_if.up_pulse),   0);
        chk("reset_up_level",   int'(kp_if.up_level),   0);
        chk("reset_down_pulse", int'(kp_if.down_pulse), 0);
        chk("reset_down_level", int'(kp_if.down_level), 0);
        rst_n_in = 1'b1;

        // Single UP press
        clear_rec();
        repeat (10) step(0, 1);
        chk_list("press_up_pulses", up_q, '{6});
        chk_list("press_down_pulses", down_q, none);
        chk("press_up_rise", up_rise, 6);
        repeat (12) step(1, 1);

        // Bouncing UP press
        clear_rec();
        for (int i = 0; i < 5; i++) begin
            repeat (3) step(0, 1);
            step(1, 1);
        end
        repeat (12) step(0, 1);
        chk_list("bounce_up_pulses", up_q, '{26});
        repeat (12) step(1, 1);

        // DOWN held 40 cycles, auto-repeat, release
        clear_rec();
        repeat (40) step(1, 0);
        repeat (12) step(1, 1);
        chk_list("hold_down_pulses", down_q, '{6, 16, 19, 22, 25, 28, 31, 34, 37, 40, 43});
        chk("hold_down_fall", down_fall, 46);

        // Both keys, UP released at 20
        clear_rec();
        repeat (20) step(0, 0);
        repeat (20) step(1, 0);
        repeat (12) step(1, 1);
        chk_list("both_up_pulses", up_q, '{6});
        chk_list("both_down_pulses", down_q, '{6, 36, 39, 42, 45});
        chk("both_up_fall", up_fall, 26);

        // Reset while repeating
        clear_rec();
        repeat (20) step(0, 1);
        chk("pre_reset_up_level", int'(kp_if.up_level), 1);
        rst_n_in = 1'b0;
        #1;
        chk("async_reset_up_level", int'(kp_if.up_level), 0);
        chk("async_reset_up_pulse", int'(kp_if.up_pulse), 0);
        repeat (3) step(0, 1);
        rst_n_in = 1'b1;
        clear_rec();
        repeat (18) step(0, 1);
        chk_list("post_reset_up_pulses", up_q, '{6, 16});
        repeat (12) step(1, 1);

        // Short DOWN glitch
        clear_rec();
        repeat (3) step(1, 0);
        repeat (15) step(1, 1);
        chk_list("glitch_down_pulses", down_q, none);
        chk("glitch_down_rise", down_rise, -1);

        // Random key activity with occasional asynchronous reset
        for (int r = 0; r < 60; r++) begin
            int kv, len;
            kv  = $urandom_range(0, 3);
            len = $urandom_range(1, 25);
            repeat (len) step(kv[0], kv[1]);
            if ($urandom_range(0, 9) == 0) begin
                rst_n_in = 1'b0;
                #2;
                rst_n_in = 1'b1;
            end
        end
        repeat (20) step(1, 1);

        done = 1;
        @(negedge clk_in);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
